// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants and types for the stream buffer slice.
// The optional drop-on-overflow counter is enabled by defining TRDB_BUFFER_DROP_EN.
package trdb_pkg;

   localparam int unsigned BUS_DATA_WIDTH     = 32;
   localparam int unsigned TRDB_BUF_DEPTH     = 16;
   localparam int unsigned TRDB_BUF_WATERMARK = 12;
   localparam int unsigned TRDB_DROP_CNT_LEN  = 16;

   typedef logic [BUS_DATA_WIDTH-1:0] trdb_word_t;

endpackage

// File: rtl/trdb_buf_ram.sv
// Flop-based 1W1R word array: synchronous write, registered read port.
// Storage itself is not reset; only the read register is.
module trdb_buf_ram
   import trdb_pkg::*;
#(
   parameter int unsigned DEPTH = TRDB_BUF_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  trdb_word_t      i_wdata,
   input  logic            i_re,
   input  logic [AW-1:0]   i_raddr,
   output trdb_word_t      o_rdata
);

   trdb_word_t r_mem [0:DEPTH-1];
   trdb_word_t r_rdata;

   always_ff @(posedge clk_i) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read register holds its value when no read is issued.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/trdb_stream_buffer.sv
// Circular word FIFO between the byte-aligning packer and the bus reader.
// Define TRDB_BUFFER_DROP_EN to discard words on overflow instead of stalling the packer.
module trdb_stream_buffer
   import trdb_pkg::*;
#(
   parameter int unsigned DEPTH     = TRDB_BUF_DEPTH,
   parameter int unsigned WATERMARK = TRDB_BUF_WATERMARK,
   localparam int unsigned AW       = $clog2(DEPTH),
   localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic [BUS_DATA_WIDTH-1:0]     data_i,
   input  logic                          valid_i,
   output logic                          grant_o,
   input  logic                          rd_req_i,
   output logic [BUS_DATA_WIDTH-1:0]     rd_data_o,
   output logic                          rd_valid_o,
   output logic [LW-1:0]                 level_o,
   output logic                          empty_o,
   output logic                          full_o,
   output logic                          irq_o,
   output logic [TRDB_DROP_CNT_LEN-1:0]  drop_cnt_o
);

   logic [LW-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_rd_valid;
   logic          r_irq;

   logic          w_full, w_empty;
   logic          w_push, w_pop;
   logic [LW-1:0] w_level_d;
   logic          w_cross;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);

   // A full buffer never accepts a word, even if a pop frees a slot in the same cycle.
   assign w_push = valid_i && !w_full && !clear_i;
   assign w_pop  = rd_req_i && !w_empty && !clear_i;

   assign w_level_d = r_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};
   assign w_cross   = (r_level < LW'(WATERMARK)) && (w_level_d >= LW'(WATERMARK));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_irq      <= 1'b0;
      end else if (clear_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
         r_level    <= w_level_d;
         r_rd_valid <= w_pop;
         r_irq      <= w_cross;
      end
   end

   trdb_buf_ram #(
      .DEPTH (DEPTH)
   ) i_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (data_i),
      .i_re    (w_pop),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (rd_data_o)
   );

`ifdef TRDB_BUFFER_DROP_EN
   logic [TRDB_DROP_CNT_LEN-1:0] r_drop_cnt;
   logic                         w_drop;

   assign w_drop  = valid_i && w_full && !clear_i;
   assign grant_o = 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                    r_drop_cnt <= '0;
      else if (clear_i)               r_drop_cnt <= '0;
      else if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + TRDB_DROP_CNT_LEN'(1);
   end

   assign drop_cnt_o = r_drop_cnt;
`else
   assign grant_o    = !w_full;
   assign drop_cnt_o = '0;
`endif

   // The wrap bits make the pointer distance equal to the stored level at all times.
   a_ptr_level : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (r_wr_ptr - r_rd_ptr) == r_level);

   assign rd_valid_o = r_rd_valid;
   assign level_o    = r_level;
   assign empty_o    = w_empty;
   assign full_o     = w_full;
   assign irq_o      = r_irq;

endmodule

// File: tb/tb_trdb_stream_buffer.sv
// Randomized and directed bench for trdb_stream_buffer against a queue-based model.
// Build with TRDB_BUFFER_DROP_EN defined to exercise the drop-on-overflow variant.
module tb_trdb_stream_buffer;
   import trdb_pkg::*;

   localparam int DEPTH = TRDB_BUF_DEPTH;
   localparam int WM    = TRDB_BUF_WATERMARK;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic                         clk_i = 1'b0;
   logic                         rst_ni;
   logic                         clear_i;
   logic [BUS_DATA_WIDTH-1:0]    data_i;
   logic                         valid_i;
   logic                         grant_o;
   logic                         rd_req_i;
   logic [BUS_DATA_WIDTH-1:0]    rd_data_o;
   logic                         rd_valid_o;
   logic [LW-1:0]                level_o;
   logic                         empty_o;
   logic                         full_o;
   logic                         irq_o;
   logic [TRDB_DROP_CNT_LEN-1:0] drop_cnt_o;

   trdb_stream_buffer dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .grant_o    (grant_o),
      .rd_req_i   (rd_req_i),
      .rd_data_o  (rd_data_o),
      .rd_valid_o (rd_valid_o),
      .level_o    (level_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .irq_o      (irq_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   logic [BUS_DATA_WIDTH-1:0] exp_q[$];
   logic [BUS_DATA_WIDTH-1:0] exp_rd_data;
   logic                      exp_rd_valid;
   logic                      exp_irq;
   int                        exp_drop;

   int n_tests = 0;
   int n_fail  = 0;
   int irq_seen = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_grant();
`ifdef TRDB_BUFFER_DROP_EN
      return 1'b1;
`else
      return exp_q.size() < DEPTH;
`endif
   endfunction

   task automatic compare_all();
      check_val("rd_valid", {31'd0, rd_valid_o}, {31'd0, exp_rd_valid});
      check_val("rd_data", rd_data_o, exp_rd_data);
      check_val("level", 32'(level_o), 32'(exp_q.size()));
      check_val("empty", {31'd0, empty_o}, {31'd0, exp_q.size() == 0});
      check_val("full", {31'd0, full_o}, {31'd0, exp_q.size() == DEPTH});
      check_val("irq", {31'd0, irq_o}, {31'd0, exp_irq});
      check_val("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
      check_val("grant", {31'd0, grant_o}, {31'd0, exp_grant()});
      if (irq_o) irq_seen++;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_irq      = 1'b0;
      exp_drop     = 0;
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
      int old_size;
      valid_i  = v;
      data_i   = d;
      rd_req_i = r;
      clear_i  = c;
      old_size = exp_q.size();
      if (c) begin
         exp_q.delete();
         exp_rd_valid = 1'b0;
         exp_irq      = 1'b0;
         exp_drop     = 0;
      end else begin
         exp_rd_valid = r && (old_size > 0);
         if (exp_rd_valid) exp_rd_data = exp_q.pop_front();
         if (v) begin
            if (old_size < DEPTH) exp_q.push_back(d);
`ifdef TRDB_BUFFER_DROP_EN
            else if (exp_drop < 65535) exp_drop++;
`endif
         end
         exp_irq = (old_size < WM) && (exp_q.size() >= WM);
      end
      @(posedge clk_i);
      #1;
      compare_all();
   endtask

   task automatic push(input logic [31:0] d);
      cycle(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic clear();
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_ni   = 1'b0;
      clear_i  = 1'b0;
      valid_i  = 1'b0;
      rd_req_i = 1'b0;
      data_i   = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      compare_all();
      rst_ni = 1'b1;

      // Basic ordering and pop latency
      for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + 32'(i));
      for (int i = 0; i < 3; i++) pop();
      check_val("basic_last_word", rd_data_o, 32'hA5A5_0003);
      pop();

      // Overflow: stall or drop depending on build
      clear();
      for (int i = 1; i <= 20; i++) push(32'(i));
      check_val("fill_level", 32'(level_o), 32'd16);
      cycle(1'b1, 32'h99, 1'b1, 1'b0);
      cycle(1'b1, 32'h99, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) pop();

      // Watermark crossings
      clear();
      irq_seen = 0;
      for (int i = 0; i < WM; i++) push(32'h100 + 32'(i));
      pop();
      push(32'h200);
      check_val("irq_pulses", 32'(irq_seen), 32'd2);

      // Steady push+pop at level 5 across pointer wrap
      clear();
      for (int i = 0; i < 5; i++) push($urandom);
      for (int i = 0; i < 40; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
      check_val("steady_level", 32'(level_o), 32'd5);

      // Clear dominates simultaneous push and pop
      clear();
      for (int i = 0; i < 7; i++) push($urandom);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
      pop();

      // Randomized phases with varying push/pop bias
      for (int ph = 0; ph < 12; ph++) begin
         int pv, pr;
         pv = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 120; i++)
            cycle($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 199) == 0);
      end

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 6; i++) push($urandom);
      pop();
      valid_i  = 1'b0;
      rd_req_i = 1'b0;
      clear_i  = 1'b0;
      rst_ni   = 1'b0;
      #2;
      model_reset();
      compare_all();
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) push(32'hC0DE_0000 + 32'(i));
      for (int i = 0; i < 5; i++) pop();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trdb_stream_buffer.md
# trdb_stream_buffer

Word buffer directly downstream of the byte-aligning packer in the trace debugger. Accepts BUS_DATA_WIDTH-bit aligned trace words over the packer's valid/grant handshake, stores them in a circular FIFO and serves them to a software/bus reader through a registered pop port. Reports fill level, pulses an interrupt when the fill level crosses a watermark, and optionally counts words dropped on overflow.

## Interface
- DEPTH, 16, number of stored words; power of two, >= 2
- WATERMARK, 12, fill level that raises irq_o; 1..DEPTH
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous clear of buffer contents and counters
- data_i  in  BUS_DATA_WIDTH  aligned trace word from the packer
- valid_i  in  1  data_i valid
- grant_o  out  1  buffer accepts data_i this cycle
- rd_req_i  in  1  pop request from reader
- rd_data_o  out  BUS_DATA_WIDTH  popped word, registered
- rd_valid_o  out  1  rd_data_o holds a freshly popped word (one-cycle pulse)
- level_o  out  $clog2(DEPTH)+1  current word count, 0..DEPTH
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- irq_o  out  1  one-cycle watermark-crossing pulse
- drop_cnt_o  out  16  words discarded on overflow (drop mode only)

## Operation
- Push: valid_i && grant_o writes data_i at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop: rd_req_i && !empty_o reads at rd_ptr into rd_data_o, rd_ptr increments modulo DEPTH, rd_valid_o = 1 next cycle. rd_req_i while empty: ignored, rd_valid_o = 0, rd_data_o holds its last value.
- Level: level_d = level_q + push - pop; simultaneous push and pop leaves level unchanged.
- Pointers carry one extra wrap bit; full/empty derived from level register, not pointer compare.
- No fall-through: a word pushed in cycle N is poppable from cycle N+1. Pop on empty with simultaneous push is ignored.
- irq_o = 1 for one cycle when level_q < WATERMARK and level_d >= WATERMARK; no re-fire until level drops below WATERMARK and crosses again.
- clear_i: pointers, level, drop counter to 0, rd_valid_o to 0, irq_o suppressed; priority over push and pop in the same cycle; stored RAM contents not erased.

## Timing
- Reset values: grant_o 1 (0 in stall mode only when full, hence 1), rd_data_o 0, rd_valid_o 0, level_o 0, empty_o 1, full_o 0, irq_o 0, drop_cnt_o 0.
- grant_o is combinational from level_q only, never from valid_i (packer's valid_o must not wait on grant).
- Pop latency: rd_req_i in cycle N -> rd_data_o/rd_valid_o in cycle N+1.
- level_o, empty_o, full_o, irq_o registered; update one cycle after the push/pop.
- Full with simultaneous pop: stall mode keeps grant_o = 0 that cycle (no same-cycle push-through).
- Reset asserted mid-operation: all state returns to reset values immediately; buffered words lost.

## Configuration
- TRDB_BUFFER_DROP_EN defined: grant_o tied 1; push while full discards data_i, increments drop_cnt_o (saturates at 16'hffff), FIFO contents unaffected; a pop in the same cycle still frees no slot for that word.
- Undefined: grant_o = !full_o (backpressure into packer); drop_cnt_o tied 0, counter not instantiated.

## Structure
- trdb_pkg: BUS_DATA_WIDTH (existing), TRDB_BUF_DEPTH, TRDB_BUF_WATERMARK, TRDB_DROP_CNT_LEN = 16.
- Sub-module trdb_buf_ram: flop-based 1W1R array, synchronous write, registered read; pointer/level/irq control stays in trdb_stream_buffer.

## Test plan
- Reset, push 32'hA5A5_0001..0003, pop three times -> rd_data_o 0001,0002,0003 each one cycle after rd_req_i, level_o 3->0, empty_o 1.
- Fill to 16 without pops -> full_o 1, grant_o 0 (stall mode); extra valid_i held until one pop, then accepted next cycle.
- Drop mode: 20 pushes, no pops -> level_o 16, drop_cnt_o 4, pops return words 1..16 in order.
- Push to level 11 then one push -> irq_o single pulse on level 11->12; pop to 11, push to 12 -> second pulse.
- Simultaneous push and pop at level 5 over 40 cycles (pointer wrap) -> level_o stays 5, data order preserved.
- clear_i with push and pop same cycle at level 7 -> level_o 0, rd_valid_o 0, drop_cnt_o 0 next cycle.
